// File: rtl/vga_pkg.sv
// Shared collision-map constants: address/pixel widths and fixed requester indices.
package vga_pkg;
  localparam int unsigned MAP_ADDR_W = 16;
  localparam int unsigned MAP_PIX_W  = 4;
  localparam int unsigned REQ_PLAYER = 0;
  localparam int unsigned REQ_ENEMY  = 1;
  localparam int unsigned REQ_SHOT   = 2;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted req at or after last_winner+1, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int unsigned k;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    k      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(last_winner) + 32'd1 + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!any && req[IDX_W'(k)]) begin
        any    = 1'b1;
        winner = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/map_rom_arbiter.sv
// Round-robin arbiter sharing one collision-map ROM between N_REQ requesters;
// one transaction at a time: grant, wait ROM_LAT cycles, return the pixel code.
module map_rom_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*MAP_ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [MAP_PIX_W-1:0]        rdata,
  output logic [MAP_ADDR_W-1:0]       rom_addr,
  input  logic [MAP_PIX_W-1:0]        rom_data,
  output logic                        busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        gnt_d, rvalid_d;
  logic [MAP_PIX_W-1:0]    rdata_d;
  logic [MAP_ADDR_W-1:0]   rom_addr_d;
  logic                    busy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [MAP_ADDR_W-1:0]   addr_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = addr[g*MAP_ADDR_W +: MAP_ADDR_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (req),
    .last_winner (last_q),
    .winner      (pick_idx),
    .any         (pick_any)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      cnt_q    <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      rvalid   <= rvalid_d;
      rdata    <= rdata_d;
      rom_addr <= rom_addr_d;
      busy     <= busy_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
    end
  end

  // Next-state and next-output logic; requests are only looked at in IDLE
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata;
    rom_addr_d = rom_addr;
    cnt_d      = cnt_q;
    last_d     = last_q;
    win_d      = win_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d[pick_idx] = 1'b1;
          rom_addr_d      = addr_arr[pick_idx];
          win_d           = pick_idx;
          cnt_d           = CNT_W'(ROM_LAT - 1);
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        rdata_d         = rom_data;
        rvalid_d[win_q] = 1'b1;
        last_d          = win_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
